// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - CPU, NIC and data memory signal bundle for dmem_port_arbiter
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              nic_req;
    logic              nic_wr;
    logic [ADDR_W-1:0] nic_addr;
    logic [DATA_W-1:0] nic_wdata;
    logic              nic_gnt;
    logic              nic_rvalid;
    logic [DATA_W-1:0] nic_rdata;

    logic              mem_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  nic_req, nic_wr, nic_addr, nic_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output nic_gnt, nic_rvalid, nic_rdata,
        output mem_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output nic_req, nic_wr, nic_addr, nic_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  nic_gnt, nic_rvalid, nic_rdata,
        input  mem_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data memory port between CPU and NIC
// DMEM_ARB_CPU_PRIORITY_EN selects fixed CPU priority instead of round-robin with MAX_HOLD.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_NIC = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last_nic, last_nic_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              rd_pend, rd_pend_nxt;
    logic              rd_nic, rd_nic_nxt;

    logic              gnt_cpu;
    logic              gnt_nic;
    logic              gnt_wr;
    logic              cpu_rv;
    logic              nic_rv;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            last_nic <= 1'b1;
            hold_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_nic   <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_nic <= last_nic_nxt;
            hold_cnt <= hold_cnt_nxt;
            rd_pend  <= rd_pend_nxt;
            rd_nic   <= rd_nic_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_nic_nxt = last_nic;
        hold_cnt_nxt = hold_cnt;
        rd_pend_nxt  = 1'b0;
        rd_nic_nxt   = rd_nic;
        if (gnt_cpu || gnt_nic) begin
            state_nxt    = gnt_nic ? OWN_NIC : OWN_CPU;
            last_nic_nxt = gnt_nic;
`ifdef DMEM_ARB_CPU_PRIORITY_EN
            hold_cnt_nxt = '0;
`else
            // Streak continues only when the grantee already owned the port last cycle.
            if ((gnt_cpu && state == OWN_CPU) || (gnt_nic && state == OWN_NIC)) begin
                hold_cnt_nxt = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + HOLD_ONE;
            end else begin
                hold_cnt_nxt = HOLD_ONE;
            end
`endif
            if (!gnt_wr) begin
                rd_pend_nxt = 1'b1;
                rd_nic_nxt  = gnt_nic;
            end
        end else begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
        end
    end

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_nic = 1'b0;
`ifdef DMEM_ARB_CPU_PRIORITY_EN
        gnt_cpu = bus.cpu_req;
        gnt_nic = bus.nic_req & ~bus.cpu_req;
`else
        if (bus.cpu_req && bus.nic_req) begin
            case (state)
                OWN_CPU: gnt_cpu = (hold_cnt < HOLD_MAX);
                OWN_NIC: gnt_cpu = (hold_cnt == HOLD_MAX);
                default: gnt_cpu = last_nic;
            endcase
            gnt_nic = ~gnt_cpu;
        end else begin
            gnt_cpu = bus.cpu_req;
            gnt_nic = bus.nic_req;
        end
`endif
        // Nothing may reach the memory while reset is held, even with requests high.
        if (!reset) begin
            gnt_cpu = 1'b0;
            gnt_nic = 1'b0;
        end

        bus.cpu_gnt   = gnt_cpu;
        bus.nic_gnt   = gnt_nic;
        bus.mem_en    = gnt_cpu | gnt_nic;
        bus.mem_wr_en = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        gnt_wr        = 1'b0;
        if (gnt_cpu) begin
            gnt_wr        = bus.cpu_wr;
            bus.mem_wr_en = bus.cpu_wr;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (gnt_nic) begin
            gnt_wr        = bus.nic_wr;
            bus.mem_wr_en = bus.nic_wr;
            bus.mem_addr  = bus.nic_addr;
            bus.mem_wdata = bus.nic_wdata;
        end

        cpu_rv         = reset & rd_pend & ~rd_nic;
        nic_rv         = reset & rd_pend & rd_nic;
        bus.cpu_rvalid = cpu_rv;
        bus.nic_rvalid = nic_rv;
        bus.cpu_rdata  = cpu_rv ? bus.mem_rdata : '0;
        bus.nic_rdata  = nic_rv ? bus.mem_rdata : '0;
    end

endmodule
